ysyx_22040759_req_arbiter: RTL and testbench

- Parametrised successor to the MEM-stage request splitter.
- Accepts memory requests from NUM_CH requesters (channel 0 = IF fetch, channel 1 = MEM stage by default) and arbitrates them round-robin.
- Latches the winning request and issues it on a single downstream read or write channel, which feeds the AXI bridge.
- Routes the completion and read data back to the granted requester only. One transaction is outstanding at a time.

---
 rtl/ysyx_22040759_req_arbiter_if.sv | 44 ++++
 rtl/ysyx_22040759_req_arbiter.sv | 117 +++++++++++
 tb/tb_ysyx_22040759_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_req_arbiter_if.sv
// Requester and downstream bus bundle for the request arbiter.
// master = arbiter side, slave = requesters plus AXI bridge side.
interface ysyx_22040759_req_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int AW     = 64,
   parameter int DW     = 64
);
   logic [NUM_CH-1:0]    req_valid_i;
   logic [NUM_CH-1:0]    req_wen_i;
   logic [NUM_CH*AW-1:0] req_addr_i;
   logic [NUM_CH*DW-1:0] req_wdata_i;
   logic [NUM_CH*2-1:0]  req_size_i;
   logic [NUM_CH-1:0]    resp_valid_o;
   logic [DW-1:0]        resp_rdata_o;
   logic                 busy_o;
   logic                 rd_addr_valid_o;
   logic [AW-1:0]        rd_addr_o;
   logic [1:0]           rd_size_o;
   logic                 rd_data_valid_i;
   logic [DW-1:0]        rd_data_i;
   logic                 wr_addr_valid_o;
   logic [AW-1:0]        wr_addr_o;
   logic [DW-1:0]        wr_data_o;
   logic [1:0]           wr_size_o;
   logic                 wr_data_valid_i;

   modport master (
      input  req_valid_i, req_wen_i, req_addr_i,
      input  req_wdata_i, req_size_i,
      input  rd_data_valid_i, rd_data_i, wr_data_valid_i,
      output resp_valid_o, resp_rdata_o, busy_o,
      output rd_addr_valid_o, rd_addr_o, rd_size_o,
      output wr_addr_valid_o, wr_addr_o, wr_data_o, wr_size_o
   );

   modport slave (
      output req_valid_i, req_wen_i, req_addr_i,
      output req_wdata_i, req_size_i,
      output rd_data_valid_i, rd_data_i, wr_data_valid_i,
      input  resp_valid_o, resp_rdata_o, busy_o,
      input  rd_addr_valid_o, rd_addr_o, rd_size_o,
      input  wr_addr_valid_o, wr_addr_o, wr_data_o, wr_size_o
   );
endinterface

// File: rtl/ysyx_22040759_req_arbiter.sv
// Round-robin arbiter: NUM_CH requesters onto one read/write channel,
// one transaction outstanding, response routed back to the granted requester.
module ysyx_22040759_req_arbiter #(
   parameter int NUM_CH = 2,
   parameter int AW     = 64,
   parameter int DW     = 64
) (
   input logic clock,
   input logic reset,
   ysyx_22040759_req_arbiter_if.master bus
);
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   last_grant;
   logic            wen;

   logic [GW-1:0]   pick;
   logic            sel_wen;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic [1:0]      sel_size;
   int              best_d;
   int              d;

   // Smallest rotational distance past last_grant wins.
   always_comb begin
      pick      = '0;
      sel_wen   = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_size  = '0;
      best_d    = NUM_CH;
      d         = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         d = (c + NUM_CH - 1 - int'(last_grant)) % NUM_CH;
         if (bus.req_valid_i[c] && d < best_d) begin
            best_d    = d;
            pick      = GW'(c);
            sel_wen   = bus.req_wen_i[c];
            sel_addr  = bus.req_addr_i[c*AW +: AW];
            sel_wdata = bus.req_wdata_i[c*DW +: DW];
            sel_size  = bus.req_size_i[c*2 +: 2];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         grant               <= '0;
         last_grant          <= GW'(NUM_CH - 1);
         wen                 <= 1'b0;
         bus.resp_valid_o    <= '0;
         bus.resp_rdata_o    <= '0;
         bus.busy_o          <= 1'b0;
         bus.rd_addr_valid_o <= 1'b0;
         bus.rd_addr_o       <= '0;
         bus.rd_size_o       <= '0;
         bus.wr_addr_valid_o <= 1'b0;
         bus.wr_addr_o       <= '0;
         bus.wr_data_o       <= '0;
         bus.wr_size_o       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|bus.req_valid_i) begin
                  state               <= BUSY;
                  grant               <= pick;
                  wen                 <= sel_wen;
                  bus.busy_o          <= 1'b1;
                  bus.rd_addr_valid_o <= !sel_wen;
                  bus.rd_addr_o       <= sel_wen ? '0 : sel_addr;
                  bus.rd_size_o       <= sel_wen ? '0 : sel_size;
                  bus.wr_addr_valid_o <= sel_wen;
                  bus.wr_addr_o       <= sel_wen ? sel_addr : '0;
                  bus.wr_data_o       <= sel_wen ? sel_wdata : '0;
                  bus.wr_size_o       <= sel_wen ? sel_size : '0;
               end
            end
            BUSY: begin
               if (!wen && bus.rd_data_valid_i) begin
                  state               <= RESP;
                  bus.rd_addr_valid_o <= 1'b0;
                  bus.rd_addr_o       <= '0;
                  bus.rd_size_o       <= '0;
                  bus.resp_valid_o    <= NUM_CH'(1) << grant;
                  bus.resp_rdata_o    <= bus.rd_data_i;
               end else if (wen && bus.wr_data_valid_i) begin
                  state               <= RESP;
                  bus.wr_addr_valid_o <= 1'b0;
                  bus.wr_addr_o       <= '0;
                  bus.wr_data_o       <= '0;
                  bus.wr_size_o       <= '0;
                  bus.resp_valid_o    <= NUM_CH'(1) << grant;
                  bus.resp_rdata_o    <= '0;
               end
            end
            RESP: begin
               state            <= IDLE;
               last_grant       <= grant;
               bus.busy_o       <= 1'b0;
               bus.resp_valid_o <= '0;
               bus.resp_rdata_o <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22040759_req_arbiter.sv
// Scoreboard bench: two arbiter instances (2ch/64b and 4ch/32b addr).
// Stimulus pushes expected responses; negedge monitors pop and compare.
module tb_ysyx_22040759_req_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ysyx_22040759_req_arbiter_if #(.NUM_CH(2), .AW(64), .DW(64)) a_if ();
   ysyx_22040759_req_arbiter_if #(.NUM_CH(4), .AW(32), .DW(64)) b_if ();

   ysyx_22040759_req_arbiter #(.NUM_CH(2), .AW(64), .DW(64)) dut_a (
      .clock(clock), .reset(reset), .bus(a_if.master)
   );
   ysyx_22040759_req_arbiter #(.NUM_CH(4), .AW(32), .DW(64)) dut_b (
      .clock(clock), .reset(reset), .bus(b_if.master)
   );

   typedef struct packed {
      logic [3:0]  ch;
      logic [63:0] d;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic samp();
      @(negedge clock);
   endtask

   always @(negedge clock) begin : mon_a
      exp_t e;
      if (a_if.resp_valid_o != '0) begin
         if (qa.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL a_resp_unexpected: got %b, required none",
                     a_if.resp_valid_o);
         end else begin
            e = qa.pop_front();
            chk("a_resp_ch", a_if.resp_valid_o, e.ch);
            chk("a_resp_rdata", a_if.resp_rdata_o, e.d);
         end
      end
   end

   always @(negedge clock) begin : mon_b
      exp_t e;
      if (b_if.resp_valid_o != '0) begin
         if (qb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL b_resp_unexpected: got %b, required none",
                     b_if.resp_valid_o);
         end else begin
            e = qb.pop_front();
            chk("b_resp_ch", b_if.resp_valid_o, e.ch);
            chk("b_resp_rdata", b_if.resp_rdata_o, e.d);
         end
      end
   end

   // Request on A; completion pulse in BUSY cycle dly; spur adds
   // opposite-direction pulses in cycle 1 and alongside completion.
   task automatic xact_a(input logic ch, input logic w,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [1:0] sz, input int dly,
                         input logic [63:0] rdat, input bit spur);
      exp_t e;
      a_if.req_valid_i[ch]              = 1'b1;
      a_if.req_wen_i[ch]                = w;
      a_if.req_addr_i[int'(ch)*64 +: 64]  = addr;
      a_if.req_wdata_i[int'(ch)*64 +: 64] = wd;
      a_if.req_size_i[int'(ch)*2 +: 2]    = sz;
      e.ch = ch ? 4'b0010 : 4'b0001;
      e.d  = w ? 64'h0 : rdat;
      qa.push_back(e);
      for (int k = 1; k <= dly; k++) begin
         step();
         a_if.rd_data_valid_i = 1'b0;
         a_if.wr_data_valid_i = 1'b0;
         a_if.rd_data_i       = '0;
         if (k == 1) a_if.req_addr_i[int'(ch)*64 +: 64] = ~addr;
         if (spur && (k == 1 || k == dly)) begin
            if (w) a_if.rd_data_valid_i = 1'b1;
            else   a_if.wr_data_valid_i = 1'b1;
            a_if.rd_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         if (k == dly) begin
            if (w) a_if.wr_data_valid_i = 1'b1;
            else   a_if.rd_data_valid_i = 1'b1;
            if (!w) a_if.rd_data_i = rdat;
         end
         samp();
         chk("a_busy", a_if.busy_o, 1'b1);
         chk("a_rd_valid", a_if.rd_addr_valid_o, !w);
         chk("a_wr_valid", a_if.wr_addr_valid_o, w);
         chk("a_rd_addr", a_if.rd_addr_o, w ? 64'h0 : addr);
         chk("a_rd_size", a_if.rd_size_o, w ? 2'b00 : sz);
         chk("a_wr_addr", a_if.wr_addr_o, w ? addr : 64'h0);
         chk("a_wr_data", a_if.wr_data_o, w ? wd : 64'h0);
         chk("a_wr_size", a_if.wr_size_o, w ? sz : 2'b00);
      end
      step();
      a_if.rd_data_valid_i = 1'b0;
      a_if.wr_data_valid_i = 1'b0;
      a_if.rd_data_i       = '0;
      samp();
      chk("a_resp_rd_valid", a_if.rd_addr_valid_o, 1'b0);
      chk("a_resp_wr_valid", a_if.wr_addr_valid_o, 1'b0);
      step();
      a_if.req_valid_i[ch] = 1'b0;
      samp();
      chk("a_idle_busy", a_if.busy_o, 1'b0);
      chk("a_idle_rdata", a_if.resp_rdata_o, 64'h0);
   endtask

   initial begin : stim
      exp_t e;
      logic c;
      a_if.req_valid_i = '0; a_if.req_wen_i = '0;
      a_if.req_addr_i = '0; a_if.req_wdata_i = '0;
      a_if.req_size_i = '0; a_if.rd_data_valid_i = 1'b0;
      a_if.rd_data_i = '0; a_if.wr_data_valid_i = 1'b0;
      b_if.req_valid_i = '0; b_if.req_wen_i = '0;
      b_if.req_addr_i = '0; b_if.req_wdata_i = '0;
      b_if.req_size_i = '0; b_if.rd_data_valid_i = 1'b0;
      b_if.rd_data_i = '0; b_if.wr_data_valid_i = 1'b0;
      reset = 1'b1;
      step();
      step();
      samp();
      chk("rst_a_resp", a_if.resp_valid_o, 2'b00);
      chk("rst_a_busy", a_if.busy_o, 1'b0);
      chk("rst_a_rd_valid", a_if.rd_addr_valid_o, 1'b0);
      chk("rst_a_wr_valid", a_if.wr_addr_valid_o, 1'b0);
      chk("rst_a_rdata", a_if.resp_rdata_o, 64'h0);
      chk("rst_b_busy", b_if.busy_o, 1'b0);
      chk("rst_b_rd_valid", b_if.rd_addr_valid_o, 1'b0);
      step();
      reset = 1'b0;

      xact_a(1'b1, 1'b0, 64'h8000_0010, 64'h0, 2'b11, 3,
             64'hDEAD_BEEF_0123_4567, 1'b0);
      xact_a(1'b0, 1'b1, 64'h8000_0100, 64'h55, 2'b00, 2, 64'h0, 1'b0);
      xact_a(1'b0, 1'b0, 64'h8000_0200, 64'h0, 2'b10, 3,
             64'h1111_2222_3333_4444, 1'b1);
      xact_a(1'b1, 1'b1, 64'h8000_0300, 64'hABCD, 2'b01, 2, 64'h0, 1'b1);

      // Contention from reset: expect ch0, ch1, ch0, ch1.
      reset = 1'b1;
      step();
      reset = 1'b0;
      a_if.req_wen_i = 2'b00;
      a_if.req_addr_i[0 +: 64]  = 64'h8000_1000;
      a_if.req_addr_i[64 +: 64] = 64'h8000_2000;
      a_if.req_valid_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         c = k[0];
         step();
         a_if.req_valid_i     = 2'b11;
         a_if.rd_data_valid_i = 1'b1;
         a_if.rd_data_i       = 64'hC0DE_0000 + 64'(k);
         e.ch = c ? 4'b0010 : 4'b0001;
         e.d  = 64'hC0DE_0000 + 64'(k);
         qa.push_back(e);
         samp();
         chk("cont_grant_addr", a_if.rd_addr_o,
             c ? 64'h8000_2000 : 64'h8000_1000);
         step();
         a_if.rd_data_valid_i = 1'b0;
         a_if.rd_data_i       = '0;
         step();
         a_if.req_valid_i = (k == 3) ? 2'b00 : (c ? 2'b01 : 2'b10);
      end
      step();
      samp();
      chk("cont_end_busy", a_if.busy_o, 1'b0);

      // Reset while BUSY, then a late completion pulse in IDLE.
      a_if.req_valid_i = 2'b10;
      a_if.req_wen_i   = 2'b00;
      a_if.req_addr_i[64 +: 64] = 64'h8000_3000;
      step();
      samp();
      chk("rstbusy_rd_valid", a_if.rd_addr_valid_o, 1'b1);
      step();
      reset = 1'b1;
      a_if.req_valid_i = 2'b00;
      step();
      reset = 1'b0;
      samp();
      chk("rstbusy_rd_valid0", a_if.rd_addr_valid_o, 1'b0);
      chk("rstbusy_rd_addr0", a_if.rd_addr_o, 64'h0);
      chk("rstbusy_busy0", a_if.busy_o, 1'b0);
      chk("rstbusy_resp0", a_if.resp_valid_o, 2'b00);
      step();
      a_if.rd_data_valid_i = 1'b1;
      a_if.rd_data_i       = 64'h7777;
      step();
      a_if.rd_data_valid_i = 1'b0;
      samp();
      chk("late_pulse_busy", a_if.busy_o, 1'b0);
      step();
      samp();
      chk("late_pulse_busy2", a_if.busy_o, 1'b0);
      chk("late_pulse_resp", a_if.resp_valid_o, 2'b00);

      // Four channels: ch1 alone, then ch1+ch3 -> ch3 first, then ch1.
      b_if.req_wen_i = 4'b0000;
      b_if.req_addr_i[32 +: 32] = 32'h100;
      b_if.req_valid_i = 4'b0010;
      step();
      b_if.rd_data_valid_i = 1'b1;
      b_if.rd_data_i       = 64'hB1;
      e.ch = 4'b0010;
      e.d  = 64'hB1;
      qb.push_back(e);
      samp();
      chk("b_first_addr", b_if.rd_addr_o, 32'h100);
      step();
      b_if.rd_data_valid_i = 1'b0;
      step();
      b_if.req_valid_i = 4'b0000;
      b_if.req_addr_i[32 +: 32] = 32'h111;
      b_if.req_addr_i[96 +: 32] = 32'h333;
      step();
      b_if.req_valid_i = 4'b1010;
      for (int k = 0; k < 2; k++) begin
         step();
         b_if.rd_data_valid_i = 1'b1;
         b_if.rd_data_i       = 64'hB3 + 64'(k);
         e.ch = (k == 0) ? 4'b1000 : 4'b0010;
         e.d  = 64'hB3 + 64'(k);
         qb.push_back(e);
         samp();
         chk("b_grant_addr", b_if.rd_addr_o,
             (k == 0) ? 32'h333 : 32'h111);
         step();
         b_if.rd_data_valid_i = 1'b0;
         step();
         b_if.req_valid_i = (k == 0) ? 4'b0010 : 4'b0000;
      end

      step();
      step();
      samp();
      chk("a_queue_empty", qa.size(), 0);
      chk("b_queue_empty", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end
endmodule
